// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
//  - DATA_WIDTH_DFLT : default operand/result width
//  - OP_*            : 4-bit opcode encodings understood by the alu
//  - state_e         : arbiter FSM state encoding
package alu_arbiter_pkg;

   localparam int unsigned DATA_WIDTH_DFLT = 16;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_CMP  = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath.
//  opcode_i   : operation select (OP_* from alu_arbiter_pkg)
//  a_i, b_i   : operands (b_i is the immediate for OP_ADDI)
//  result_o   : result, truncated to Width bits
//  cmp_flag_o : unsigned a_i < b_i, produced for every opcode
module alu
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned Width = DATA_WIDTH_DFLT
) (
   input  logic [3:0]       opcode_i,
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   output logic [Width-1:0] result_o,
   output logic             cmp_flag_o
);

   always_comb begin
      cmp_flag_o = (a_i < b_i);
      case (opcode_i)
         OP_ADD, OP_ADDI: result_o = a_i + b_i;
         OP_SUB:          result_o = a_i - b_i;
         OP_MUL:          result_o = a_i * b_i;  // low Width bits kept
         OP_CMP:          result_o = {{(Width-1){1'b0}}, cmp_flag_o};
         default:         result_o = '0;         // undefined opcodes yield zero
      endcase
   end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of req_i scanning from ptr_i upward, wrapping.
//  req_i : request vector
//  ptr_i : highest-priority index this cycle
//  gnt_o : one-hot grant (zero when no request)
//  idx_o : index of the granted request
//  any_o : at least one request present
module alu_arbiter_rr_pick #(
   parameter int unsigned NumReq = 4
) (
   input  logic [NumReq-1:0]         req_i,
   input  logic [$clog2(NumReq)-1:0] ptr_i,
   output logic [NumReq-1:0]         gnt_o,
   output logic [$clog2(NumReq)-1:0] idx_o,
   output logic                      any_o
);

   localparam int unsigned IdxW = $clog2(NumReq);

   logic [IdxW-1:0] cand;
   logic            found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      cand  = '0;
      found = 1'b0;
      // NumReq is a power of two, so the index add wraps for free.
      for (int unsigned k = 0; k < NumReq; k++) begin
         cand = ptr_i + IdxW'(k);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu among NUM_REQ requesters with round-robin grant.
//  clk, rst_n  : clock, asynchronous active-low reset
//  req_valid   : per-requester request valid
//  req_ready   : one-hot grant, asserted only in IDLE
//  req_opcode  : packed opcodes, requester i at [4i+3:4i]
//  req_a/req_b : packed operands, requester i at [DATA_WIDTH*i +: DATA_WIDTH]
//  rsp_valid   : one-hot single-cycle response pulse to the granted requester
//  rsp_result  : registered result, held between responses
//  rsp_cmp     : registered compare flag, held between responses
//  busy        : high while an operation is in EXEC or RESP
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*4-1:0]          req_opcode,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_result,
   output logic                          rsp_cmp,
   output logic                          busy
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

   state_e                state_q, state_d;
   logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]       gnt_idx_q, gnt_idx_d;
   logic [3:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic                  rsp_cmp_q, rsp_cmp_d;

   logic [NUM_REQ-1:0]    pick_gnt;
   logic [IdxW-1:0]       pick_idx;
   logic                  pick_any;
   logic [3:0]            sel_op;
   logic [DATA_WIDTH-1:0] sel_a, sel_b;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_cmp;

   alu_arbiter_rr_pick #(
      .NumReq (NUM_REQ)
   ) u_rr_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // The alu only ever sees captured operands, never the live request buses.
   alu #(
      .Width (DATA_WIDTH)
   ) u_alu (
      .opcode_i   (op_q),
      .a_i        (a_q),
      .b_i        (b_q),
      .result_o   (alu_result),
      .cmp_flag_o (alu_cmp)
   );

   // Operand mux for the requester currently winning arbitration.
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IdxW'(i)) begin
            sel_op = req_opcode[4*i +: 4];
            sel_a  = req_a[DATA_WIDTH*i +: DATA_WIDTH];
            sel_b  = req_b[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_idx_d    = gnt_idx_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      cnt_d        = cnt_q;
      rsp_result_d = rsp_result_q;
      rsp_cmp_d    = rsp_cmp_q;
      req_ready    = '0;
      rsp_valid    = '0;
      busy         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               req_ready = pick_gnt;
               gnt_idx_d = pick_idx;
               op_d      = sel_op;
               a_d       = sel_a;
               b_d       = sel_b;
               cnt_d     = (sel_op == OP_MUL) ? CntW'(MUL_CYCLES - 1) : '0;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               rsp_result_d = alu_result;
               rsp_cmp_d    = alu_cmp;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         ST_RESP: begin
            busy                 = 1'b1;
            rsp_valid[gnt_idx_q] = 1'b1;
            rr_ptr_d             = gnt_idx_q + IdxW'(1);  // wraps at NUM_REQ
            state_d              = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         gnt_idx_q    <= '0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         cnt_q        <= '0;
         rsp_result_q <= '0;
         rsp_cmp_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_idx_q    <= gnt_idx_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         cnt_q        <= cnt_d;
         rsp_result_q <= rsp_result_d;
         rsp_cmp_q    <= rsp_cmp_d;
      end
   end

   assign rsp_result = rsp_result_q;
   assign rsp_cmp    = rsp_cmp_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: cycle-level transaction model checked every negedge,
// directed scenarios with literal expectations, then a randomized phase.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int MC = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req_valid, req_ready, rsp_valid;
   logic [NR*4-1:0]  req_opcode;
   logic [NR*DW-1:0] req_a, req_b;
   logic [DW-1:0]    rsp_result;
   logic             rsp_cmp, busy;

   alu_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MUL_CYCLES (MC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .rsp_cmp    (rsp_cmp),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Transaction-level model state
   int            cyc      = 0;
   int            free_at  = 0;
   int            rsp_at   = -1;
   int            grant_at = -1;
   int            m_g      = 0;
   int            m_ptr    = 0;
   logic [DW-1:0] m_res    = '0;
   logic          m_cmp    = 1'b0;
   logic [DW-1:0] hold_res = '0;
   logic          hold_cmp = 1'b0;
   logic [NR-1:0] hs       = '0;

   // Observed DUT events, for directed literal checks
   int g_log[$], g_cyc[$], r_idx[$], r_cyc[$], r_res[$], r_cmp[$];

   logic          rand_mode = 1'b0;
   logic [NR-1:0] sticky    = '0;

   function automatic int pick(input logic [NR-1:0] v, input int p);
      for (int k = 0; k < NR; k++) begin
         if (v[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
      longint m = longint'(1) << DW;
      longint x;
      case (op)
         OP_ADD, OP_ADDI: x = longint'(a) + longint'(b);
         OP_SUB:          x = longint'(a) - longint'(b) + m;
         OP_MUL:          x = longint'(a) * longint'(b);
         OP_CMP:          x = (a < b) ? 1 : 0;
         default:         x = 0;
      endcase
      return DW'(x % m);
   endfunction

   function automatic int at_q(input int q[$], input int k);
      if (k < q.size()) return q[k];
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [NR-1:0] v);
      for (int k = 0; k < NR; k++) if (v[k]) return k;
      return -1;
   endfunction

   always @(negedge clk) begin : compare
      logic [NR-1:0] exp_ready, exp_rsp;
      logic [3:0]    op;
      logic [DW-1:0] a, b;
      int            g;
      if (!rst_n) begin
         cyc = 0; free_at = 0; rsp_at = -1; grant_at = -1; m_ptr = 0;
         hold_res = '0; hold_cmp = 1'b0; hs = '0;
         check("rst_ready", 32'(req_ready), 0);
         check("rst_rsp_valid", 32'(rsp_valid), 0);
         check("rst_result", 32'(rsp_result), 0);
         check("rst_cmp", 32'(rsp_cmp), 0);
         check("rst_busy", 32'(busy), 0);
      end else begin
         exp_ready = '0;
         exp_rsp   = '0;
         if (cyc == rsp_at) begin
            exp_rsp[m_g] = 1'b1;
            hold_res     = m_res;
            hold_cmp     = m_cmp;
         end
         if (cyc >= free_at) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) begin
               exp_ready[g] = 1'b1;
               op       = req_opcode[g*4 +: 4];
               a        = req_a[g*DW +: DW];
               b        = req_b[g*DW +: DW];
               m_res    = ref_result(op, a, b);
               m_cmp    = (a < b);
               m_g      = g;
               grant_at = cyc;
               rsp_at   = cyc + ((op == OP_MUL) ? 1 + MC : 2);
               free_at  = rsp_at + 1;
               m_ptr    = (g + 1) % NR;
            end
         end
         check("req_ready", 32'(req_ready), 32'(exp_ready));
         check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
         check("rsp_result", 32'(rsp_result), 32'(hold_res));
         check("rsp_cmp", 32'(rsp_cmp), 32'(hold_cmp));
         check("busy", 32'(busy),
               32'((grant_at >= 0 && cyc > grant_at && cyc <= rsp_at) ? 1 : 0));
         hs = req_valid & req_ready;
         if (|req_ready) begin
            g_log.push_back(onehot_idx(req_ready));
            g_cyc.push_back(cyc);
         end
         if (|rsp_valid) begin
            r_idx.push_back(onehot_idx(rsp_valid));
            r_cyc.push_back(cyc);
            r_res.push_back(int'(rsp_result));
            r_cmp.push_back(int'(rsp_cmp));
         end
         cyc++;
      end
   end

   task automatic clear_logs();
      g_log.delete(); g_cyc.delete(); r_idx.delete();
      r_cyc.delete(); r_res.delete(); r_cmp.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (rand_mode) begin
            if (hs[i] || !req_valid[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req_valid[i]          = 1'b1;
                  req_opcode[i*4 +: 4]  = 4'($urandom_range(0, 7));
                  req_a[i*DW +: DW]     = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 9))
                                                                      : DW'($urandom);
                  req_b[i*DW +: DW]     = DW'($urandom);
               end else begin
                  req_valid[i] = 1'b0;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;  // withdraw before grant
            end
         end else if (hs[i] && !sticky[i]) begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      tick();
      rst_n     = 1'b0;
      req_valid = '0;
      tick();
      tick();
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
      req_valid[i]         = 1'b1;
      req_opcode[i*4 +: 4] = op;
      req_a[i*DW +: DW]    = a;
      req_b[i*DW +: DW]    = b;
   endtask

   task automatic wait_rsp(input int n, input int budget);
      int k = 0;
      while (r_res.size() < n && k < budget) begin
         tick();
         k++;
      end
      if (r_res.size() < n) begin
         n_vec++; n_err++;
         $display("FAIL wait_rsp: got %0d responses, required %0d", r_res.size(), n);
      end
   endtask

   task automatic wait_grants(input int n, input int budget);
      int k = 0;
      while (g_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      if (g_log.size() < n) begin
         n_vec++; n_err++;
         $display("FAIL wait_grants: got %0d grants, required %0d", g_log.size(), n);
      end
   endtask

   logic [3:0]    cmp_op_a [3] = '{4'd2, 4'd8, 4'd5};
   logic [3:0]    cmp_op_b [3] = '{4'd8, 4'd2, 4'd5};
   logic          cmp_exp  [3] = '{1'b1, 1'b0, 1'b0};

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      clear_logs();

      // 1: single ADD
      set_req(0, OP_ADD, 7, 5);
      wait_rsp(1, 20);
      check("t1_grant", at_q(g_log, 0), 0);
      check("t1_rsp_idx", at_q(r_idx, 0), 0);
      check("t1_result", at_q(r_res, 0), 12);
      check("t1_cmp", at_q(r_cmp, 0), 0);
      check("t1_latency", at_q(r_cyc, 0) - at_q(g_cyc, 0), 2);

      // 2: all four at once
      do_reset();
      set_req(0, OP_SUB, 9, 4);
      set_req(1, OP_ADD, 7, 5);
      set_req(2, OP_ADDI, 10, 15);
      set_req(3, OP_CMP, 2, 8);
      wait_rsp(4, 40);
      for (int k = 0; k < 4; k++) check("t2_grant_order", at_q(g_log, k), k);
      check("t2_r0_result", at_q(r_res, 0), 5);
      check("t2_r1_result", at_q(r_res, 1), 12);
      check("t2_r2_result", at_q(r_res, 2), 25);
      check("t2_r3_cmp", at_q(r_cmp, 3), 1);
      for (int k = 0; k < 3; k++) check("t2_spacing", at_q(r_cyc, k + 1) - at_q(r_cyc, k), 3);

      // 3: fairness between two persistent requesters
      do_reset();
      sticky = 4'b1010;
      set_req(1, OP_ADD, 1, 1);
      set_req(3, OP_ADD, 2, 2);
      wait_grants(4, 40);
      check("t3_grant0", at_q(g_log, 0), 1);
      check("t3_grant1", at_q(g_log, 1), 3);
      check("t3_grant2", at_q(g_log, 2), 1);
      check("t3_grant3", at_q(g_log, 3), 3);
      sticky    = '0;
      req_valid = '0;
      repeat (8) tick();

      // 4: multi-cycle MUL
      do_reset();
      set_req(0, OP_MUL, 6, 3);
      wait_rsp(1, 20);
      check("t4_mul_small", at_q(r_res, 0), 18);
      check("t4_mul_latency", at_q(r_cyc, 0) - at_q(g_cyc, 0), 1 + MC);
      clear_logs();
      set_req(1, OP_MUL, 300, 300);
      wait_rsp(1, 20);
      check("t4_mul_trunc", at_q(r_res, 0), 32'h5F90);

      // 5: CMP and hold between responses
      for (int k = 0; k < 3; k++) begin
         clear_logs();
         set_req(2, OP_CMP, DW'(cmp_op_a[k]), DW'(cmp_op_b[k]));
         wait_rsp(1, 20);
         check("t5_cmp", at_q(r_cmp, 0), 32'(cmp_exp[k]));
         repeat (2) tick();
         check("t5_cmp_hold", 32'(rsp_cmp), 32'(cmp_exp[k]));
      end

      // 6: reset during a MUL's EXEC
      do_reset();
      set_req(2, OP_MUL, 7, 7);
      wait_grants(1, 20);
      check("t6_busy_exec", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("t6_async_busy", 32'(busy), 0);
      check("t6_async_rsp_valid", 32'(rsp_valid), 0);
      check("t6_async_result", 32'(rsp_result), 0);
      tick();
      tick();
      rst_n = 1'b1;
      check("t6_no_rsp", r_res.size(), 0);
      clear_logs();
      set_req(2, OP_MUL, 7, 7);
      set_req(0, OP_ADD, 1, 2);
      wait_grants(1, 20);
      check("t6_first_grant", at_q(g_log, 0), 0);
      wait_rsp(2, 40);
      repeat (4) tick();

      // Randomized traffic, checked by the per-cycle model
      do_reset();
      rand_mode = 1'b1;
      repeat (3000) tick();
      rand_mode = 1'b0;
      req_valid = '0;
      repeat (10) tick();
      check("rand_activity", 32'((r_res.size() > 100) ? 1 : 0), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
